// File: rtl/convol_seq_if.sv
// Load, control and result handshake bundle for convol_seq.
// Master is the environment side; slave is the convolution engine.
interface convol_seq_if #(
  parameter int W  = 8,
  parameter int OW = 2 * W + 4
);
  logic          ld_valid;
  logic          ld_sel;
  logic [W-1:0]  ld_data;
  logic          ld_ready;
  logic          clear;
  logic          start;
  logic          busy;
  logic          y_valid;
  logic          y_ready;
  logic [OW-1:0] y_data;
  logic          y_last;
  logic          done;
  logic          err;

  modport master (
    output ld_valid, ld_sel, ld_data, clear, start, y_ready,
    input  ld_ready, busy, y_valid, y_data, y_last, done, err
  );

  modport slave (
    input  ld_valid, ld_sel, ld_data, clear, start, y_ready,
    output ld_ready, busy, y_valid, y_data, y_last, done, err
  );
endinterface

// File: rtl/convol_seq.sv
// Sequential full convolution of buffered A (M) and B (N), one MAC per cycle.
// Each y[k] takes L_k CALC cycles then waits in OUT until y_ready; loads only in IDLE.
module convol_seq #(
  parameter int M = 6,
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  convol_seq_if.slave  bus
);
  localparam int OW   = 2 * W + 4;
  localparam int KMAX = M + N - 2;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int IW   = $clog2(M);
  localparam int BW   = $clog2(N);
  localparam int AW   = $clog2(M + 1);
  localparam int BCW  = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   a_cnt_q, a_cnt_d;
  logic [BCW-1:0]  b_cnt_q, b_cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [IW-1:0]   i_q, i_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic            err_q, err_d;
  logic            a_we, b_we;

  logic [W-1:0]    a_mem [M];
  logic [W-1:0]    b_mem [N];
  logic [BW-1:0]   b_idx;
  logic [2*W-1:0]  prod;

  // First and last A index contributing to y[k].
  function automatic logic [IW-1:0] lo_of(input int k);
    return (k > N - 1) ? IW'(k - N + 1) : '0;
  endfunction

  function automatic logic [IW-1:0] hi_of(input int k);
    return (k < M - 1) ? IW'(k) : IW'(M - 1);
  endfunction

  assign b_idx = BW'(int'(k_q) - int'(i_q));
  assign prod  = a_mem[i_q] * b_mem[b_idx];

  always_comb begin
    state_d = state_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    k_d     = k_q;
    i_d     = i_q;
    acc_d   = acc_q;
    err_d   = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && a_cnt_q == AW'(M) && b_cnt_q == BCW'(N)) begin
          state_d = S_CALC;
          k_d     = '0;
          i_d     = '0;
          acc_d   = '0;
        end else begin
          if (bus.start) err_d = 1'b1;
          // Clear outranks a simultaneous beat, which is dropped silently.
          if (bus.clear) begin
            a_cnt_d = '0;
            b_cnt_d = '0;
          end else if (bus.ld_valid) begin
            if (!bus.ld_sel) begin
              if (a_cnt_q == AW'(M)) err_d = 1'b1;
              else begin
                a_we    = 1'b1;
                a_cnt_d = a_cnt_q + 1'b1;
              end
            end else begin
              if (b_cnt_q == BCW'(N)) err_d = 1'b1;
              else begin
                b_we    = 1'b1;
                b_cnt_d = b_cnt_q + 1'b1;
              end
            end
          end
        end
      end
      S_CALC: begin
        acc_d = acc_q + OW'(prod);
        if (i_q == hi_of(int'(k_q))) state_d = S_OUT;
        else i_d = i_q + 1'b1;
      end
      S_OUT: begin
        if (bus.y_ready) begin
          if (k_q == KW'(KMAX)) state_d = S_DONE;
          else begin
            state_d = S_CALC;
            k_d     = k_q + 1'b1;
            i_d     = lo_of(int'(k_q) + 1);
            acc_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      k_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      k_q     <= k_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Sample storage carries no reset; the counts alone define what is valid.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[IW'(a_cnt_q)] <= bus.ld_data;
    if (b_we) b_mem[BW'(b_cnt_q)] <= bus.ld_data;
  end

  assign bus.ld_ready = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.y_valid  = (state_q == S_OUT);
  assign bus.y_data   = (state_q == S_OUT) ? acc_q : '0;
  assign bus.y_last   = (state_q == S_OUT) && (k_q == KW'(KMAX));
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = err_q;
endmodule

// File: tb/tb_convol_seq.sv
// Scoreboard bench for convol_seq: stimulus pushes expected y[k], a negedge monitor pops and compares.
module tb_convol_seq;
  localparam int M  = 6;
  localparam int N  = 5;
  localparam int W  = 8;
  localparam int OW = 2 * W + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  convol_seq_if #(.W(W)) bus();

  convol_seq #(.M(M), .N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [OW-1:0] d;
    logic          l;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            err_cnt = 0;
  int            done_cnt = 0;
  int            busy_low = 0;
  bit            stall_mode = 1'b0;
  bit            stalled = 1'b0;
  logic [OW-1:0] held_d;
  logic          held_l;
  int            av[6];
  int            bv[5];
  int            yv[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts pulses, checks stall stability, scores every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.err)  err_cnt++;
      if (bus.done) done_cnt++;
      if (bus.y_valid && !bus.y_ready) begin
        if (stalled) begin
          check("stall_hold_data", bus.y_data, held_d);
          check("stall_hold_last", bus.y_last, held_l);
        end
        stalled = 1'b1;
        held_d  = bus.y_data;
        held_l  = bus.y_last;
      end else begin
        stalled = 1'b0;
      end
      if (bus.y_valid && bus.y_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_y: got y_data %0d with nothing expected", bus.y_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("y_data", bus.y_data, e.d);
          check("y_last", bus.y_last, e.l);
        end
      end
    end
  end

  // y_ready: held high, or in stall mode low for 3 cycles at each result.
  initial begin
    int scnt;
    scnt = 0;
    bus.y_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        bus.y_ready = 1'b1;
        scnt = 0;
      end else if (bus.y_valid) begin
        if (scnt == 3) begin
          bus.y_ready = 1'b1;
          scnt = 0;
        end else begin
          bus.y_ready = 1'b0;
          scnt++;
        end
      end else begin
        bus.y_ready = 1'b0;
        scnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit sel, input int v);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_data  = W'(v);
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic load_a(input int n);
    for (int j = 0; j < n; j++) load(1'b0, av[j]);
  endtask

  task automatic load_b(input int n);
    for (int j = 0; j < n; j++) load(1'b1, bv[j]);
  endtask

  task automatic do_clear(input bit with_beat);
    bus.clear    = 1'b1;
    bus.ld_valid = with_beat;
    bus.ld_sel   = 1'b0;
    bus.ld_data  = W'(99);
    tick();
    bus.clear    = 1'b0;
    bus.ld_valid = 1'b0;
  endtask

  // Start a run and wait for done; noise drives loads and clear while busy.
  task automatic run(input string name, input bit chk_len, input bit noise);
    int  d0, e0, edges;
    bit  seen;
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      e.d = OW'(yv[k]);
      e.l = (k == 9);
      q.push_back(e);
    end
    d0 = done_cnt;
    e0 = err_cnt;
    busy_low = 0;
    edges = 0;
    seen = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (noise) begin
      bus.ld_valid = 1'b1;
      bus.ld_sel   = 1'b0;
      bus.ld_data  = W'(200);
      bus.clear    = 1'b1;
      check({name, "_ld_ready_busy"}, bus.ld_ready, 0);
    end
    repeat (600) begin
      if (!bus.busy) busy_low++;
      tick();
      edges++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    bus.ld_valid = 1'b0;
    bus.clear    = 1'b0;
    check({name, "_done_seen"}, seen, 1);
    // Run spans start edge through the DONE cycle inclusive.
    if (chk_len) check({name, "_len"}, edges + 1, M * N + (M + N - 1) + 1);
    tick();
    check({name, "_busy_held"}, busy_low, 0);
    check({name, "_back_idle"}, bus.ld_ready, 1);
    check({name, "_all_out"}, q.size(), 0);
    check({name, "_one_done"}, done_cnt - d0, 1);
    check({name, "_no_err"}, err_cnt - e0, 0);
  endtask

  task automatic reject(input string name);
    int e0;
    e0 = err_cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check({name, "_err"}, err_cnt - e0, 1);
    check({name, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int e0, d0;
    bit hit;
    bus.ld_valid = 1'b0;
    bus.ld_sel   = 1'b0;
    bus.ld_data  = '0;
    bus.clear    = 1'b0;
    bus.start    = 1'b0;
    #1;
    check("rst_ld_ready", bus.ld_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_y_valid", bus.y_valid, 0);
    check("rst_y_data", bus.y_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("post_rst_ld_ready", bus.ld_ready, 1);

    av = '{1, 4, 3, 4, 3, 1};
    bv = '{3, 2, 3, 2, 3};
    yv = '{3, 14, 20, 32, 37, 39, 28, 21, 11, 3};
    e0 = err_cnt;
    load_a(6);
    load_b(5);
    check("load_no_err", err_cnt - e0, 0);
    run("run1", 1'b1, 1'b0);
    run("rerun_noise", 1'b1, 1'b1);
    run("rerun_after_noise", 1'b1, 1'b0);
    stall_mode = 1'b1;
    run("stall", 1'b0, 1'b0);
    stall_mode = 1'b0;

    do_clear(1'b0);
    load_a(5);
    load_b(5);
    reject("start_short_a");
    load(1'b0, av[5]);
    run("run_after_6th", 1'b1, 1'b0);

    e0 = err_cnt;
    load(1'b0, 77);
    tick();
    tick();
    check("seventh_a_err", err_cnt - e0, 1);
    run("run_after_7th", 1'b1, 1'b0);
    e0 = err_cnt;
    do_clear(1'b1);
    tick();
    tick();
    check("clear_beat_no_err", err_cnt - e0, 0);
    load_b(5);
    reject("start_a_empty");
    e0 = err_cnt;
    load_a(6);
    check("reload_a_no_err", err_cnt - e0, 0);
    run("run_after_clear", 1'b1, 1'b0);

    av = '{255, 255, 255, 255, 255, 255};
    bv = '{255, 255, 255, 255, 255};
    yv = '{65025, 130050, 195075, 260100, 325125, 325125, 260100, 195075, 130050, 65025};
    do_clear(1'b0);
    load_a(6);
    load_b(5);
    run("all_255", 1'b1, 1'b0);

    av = '{1, 4, 3, 4, 3, 1};
    bv = '{3, 2, 3, 2, 3};
    yv = '{3, 14, 20, 32, 37, 39, 28, 21, 11, 3};
    do_clear(1'b0);
    load_a(6);
    load_b(5);
    for (int k = 0; k < 10; k++) begin
      exp_t e;
      e.d = OW'(yv[k]);
      e.l = (k == 9);
      q.push_back(e);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    hit = 1'b0;
    repeat (200) begin
      tick();
      if (q.size() == 6) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_k4", hit, 1);
    tick();
    check("k4_in_calc", bus.busy, 1);
    rst = 1'b0;
    #1;
    q.delete();
    d0 = done_cnt;
    check("midrst_y_valid", bus.y_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_y_data", bus.y_data, 0);
    check("midrst_y_last", bus.y_last, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_err", bus.err, 0);
    check("midrst_ld_ready", bus.ld_ready, 1);
    tick();
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    reject("start_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
